// File: rtl/burst_receiver_pkg.sv
// Shared constants, FSM states and width helper for the burst receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package burst_receiver_pkg;

    localparam int DEF_MAX_PULSES  = 50;
    localparam int DEF_IDLE_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to index 'value' distinct states; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/burst_receiver_if.sv
// Pulse-train input and burst-result outputs; optional match port under BURST_RX_MATCH_EN.
// Latency: n/a (wiring only).
// Backpressure: none; results are strobed and held, no ready path.
interface burst_receiver_if #(
    parameter int CW = 6
);

    logic          burstIn;
    logic [CW-1:0] pulseCount;
    logic          countValid;
    logic          busy;
    logic          overflow;
`ifdef BURST_RX_MATCH_EN
    logic [CW-1:0] expectedCount;
    logic          match;
`endif

`ifdef BURST_RX_MATCH_EN
    modport master (
        output burstIn,
        output expectedCount,
        input  pulseCount,
        input  countValid,
        input  busy,
        input  overflow,
        input  match
    );

    modport slave (
        input  burstIn,
        input  expectedCount,
        output pulseCount,
        output countValid,
        output busy,
        output overflow,
        output match
    );
`else
    modport master (
        output burstIn,
        input  pulseCount,
        input  countValid,
        input  busy,
        input  overflow
    );

    modport slave (
        input  burstIn,
        output pulseCount,
        output countValid,
        output busy,
        output overflow
    );
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles.
// Backpressure: none.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/burst_receiver.sv
// Counts rising edges of a pulse burst and reports the total once the line idles; optional BURST_RX_MATCH_EN compare.
// Latency: countValid in the (IDLE_CYCLES+3)th cycle after the last falling edge of burstIn.
// Backpressure: none; result strobed for one cycle and held until the next burst completes.
module burst_receiver
    import burst_receiver_pkg::*;
#(
    parameter int MAX_PULSES  = DEF_MAX_PULSES,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    burst_receiver_if.slave  bus
);

    localparam int CW     = clog2(MAX_PULSES + 1);
    localparam int IW_RAW = clog2(IDLE_CYCLES);
    localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;

    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PULSES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

    logic          s;
    logic          s_d;
    logic          rise;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] work_cnt_q;
    logic [CW-1:0] work_cnt_d;
    logic [IW-1:0] idle_cnt_q;
    logic [IW-1:0] idle_cnt_d;
    logic          ovf_pend_q;
    logic          ovf_pend_d;
    logic          load_result;

    logic [CW-1:0] pulse_count_q;
    logic          overflow_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.burstIn),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_cnt_q <= '0;
            idle_cnt_q <= '0;
            ovf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_cnt_q <= work_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        work_cnt_d  = work_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        ovf_pend_d  = ovf_pend_q;
        load_result = 1'b0;

        case (state_q)
            IDLE: begin
                idle_cnt_d = '0;
                if (rise) begin
                    state_d    = COUNT;
                    work_cnt_d = CW'(1);
                    ovf_pend_d = 1'b0;
                end
            end

            COUNT: begin
                // Idle counter saturates at its terminal value instead of wrapping.
                if (s) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_LAST) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end

                if (rise) begin
                    if (work_cnt_q == MAX_CNT) begin
                        ovf_pend_d = 1'b1;
                    end else begin
                        work_cnt_d = work_cnt_q + CW'(1);
                    end
                end

                // Results are captured on entry so they are already valid during DONE.
                if (!s && (idle_cnt_q == IDLE_LAST)) begin
                    state_d     = DONE;
                    load_result = 1'b1;
                end
            end

            DONE: begin
                state_d    = IDLE;
                idle_cnt_d = '0;
            end

            default: begin
                state_d    = IDLE;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_count_q <= '0;
            overflow_q    <= 1'b0;
        end else if (load_result) begin
            pulse_count_q <= work_cnt_q;
            overflow_q    <= ovf_pend_q;
        end
    end

`ifdef BURST_RX_MATCH_EN
    logic match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else if (load_result) begin
            match_q <= (work_cnt_q == bus.expectedCount);
        end
    end

    assign bus.match = match_q;
`endif

    assign bus.pulseCount = pulse_count_q;
    assign bus.overflow   = overflow_q;
    assign bus.countValid = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_burst_receiver.sv
// Directed bench for burst_receiver; expected results queued by stimulus, checked by a monitor.
module tb_burst_receiver;
    import burst_receiver_pkg::*;

    localparam int MAXP = 50;
    localparam int IDLC = 8;
    localparam int CW   = clog2(MAXP + 1);

    typedef struct {
        int   cnt;
        logic ovf;
        logic mt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic busy_next_chk;
    exp_t exp_q[$];

    burst_receiver_if #(.CW(CW)) bus ();

    burst_receiver #(
        .MAX_PULSES  (MAXP),
        .IDLE_CYCLES (IDLC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Monitor: every countValid strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (busy_next_chk) begin
            busy_next_chk = 1'b0;
            check("busy_after_done", int'(bus.busy), 0);
        end
        if (bus.countValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_countValid actual=1 required=0 pulseCount=%0d", bus.pulseCount);
            end else begin
                e = exp_q.pop_front();
                check("pulseCount", int'(bus.pulseCount), e.cnt);
                check("overflow", int'(bus.overflow), int'(e.ovf));
`ifdef BURST_RX_MATCH_EN
                check("match", int'(bus.match), int'(e.mt));
`endif
            end
            check("busy_in_done", int'(bus.busy), 1);
            busy_next_chk = 1'b1;
        end
    end

    task automatic hold(input logic lvl, input int n);
        bus.burstIn = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
    endtask

    task automatic expect_burst(input int cnt, input logic ovf, input logic mt);
        exp_t e;
        e.cnt = cnt;
        e.ovf = ovf;
        e.mt  = mt;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_pulseCount"}, int'(bus.pulseCount), 0);
        check({tag, "_countValid"}, int'(bus.countValid), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_overflow"}, int'(bus.overflow), 0);
    endtask

    initial begin
        int k;
        checks        = 0;
        failures      = 0;
        busy_next_chk = 1'b0;
        rst_n         = 1'b0;
        bus.burstIn   = 1'b0;
`ifdef BURST_RX_MATCH_EN
        bus.expectedCount = CW'(50);
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        hold(1'b0, 4);

        // 50 pulses: exact limit, plus latency from the final falling edge.
        expect_burst(50, 1'b0, 1'b1);
        pulses(49);
        hold(1'b1, 2);
        bus.burstIn = 1'b0;
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.countValid === 1'b1) begin
                k = i;
                break;
            end
        end
        check("latency_cycles", k, IDLC + 3);
        hold(1'b0, 6);
        wait_drain();

        // 53 pulses saturate at 50 with overflow, then a short burst clears it.
        expect_burst(50, 1'b1, 1'b1);
        pulses(53);
        hold(1'b0, 20);
        wait_drain();
        expect_burst(3, 1'b0, 1'b0);
        pulses(3);
        hold(1'b0, 20);
        wait_drain();

        // A 7-cycle gap does not end the burst.
        expect_burst(20, 1'b0, 1'b0);
        pulses(9);
        hold(1'b1, 2);
        hold(1'b0, 7);
        pulses(10);
        hold(1'b0, 20);
        wait_drain();

        // An 8-cycle gap ends it; the next rise lands in DONE and is dropped,
        // so 11 pulses after the gap report 10.
        expect_burst(10, 1'b0, 1'b0);
        expect_burst(10, 1'b0, 1'b0);
        pulses(9);
        hold(1'b1, 2);
        hold(1'b0, 8);
        pulses(11);
        hold(1'b0, 20);
        wait_drain();

        // Reset mid-burst discards the partial count and clears outputs.
        pulses(25);
        rst_n = 1'b0;
        hold(1'b0, 3);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        hold(1'b0, 20);
        check("post_reset_busy", int'(bus.busy), 0);
        expect_burst(50, 1'b0, 1'b1);
        pulses(50);
        hold(1'b0, 20);
        wait_drain();

        // Line stuck high: stays busy with no report until it finally drops.
        hold(1'b1, 60);
        check("stuck_high_busy", int'(bus.busy), 1);
        expect_burst(1, 1'b0, 1'b0);
        hold(1'b0, 20);
        wait_drain();

        // One short of the limit.
        expect_burst(49, 1'b0, 1'b0);
        pulses(49);
        hold(1'b0, 20);
        wait_drain();

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
